// File: rtl/tlb_write_unit.sv
// tlb_write_unit: executes TLBR / TLBWI / TLBWR / TLBP against the
// architectural TLB table, and owns the CP0 Random and Wired registers.
// The table is held in flops because every entry is exported on tlb_table
// to the lookup units each cycle.
// Optional feature: define TLB_FLUSH_EN to add the flush_req input and the
// FLUSH state, which clears v0/v1/G of every entry one entry per cycle.

package tlb_write_unit_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic        v0;
    logic        v1;
    logic        d0;
    logic        d1;
  } tlb_entry_t;

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;
endpackage

module tlb_write_unit
  import tlb_write_unit_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [1:0]                        req_op,
  input  logic [IDX_W-1:0]                  req_index,
  input  tlb_entry_t                        req_entry,
  input  logic                              wired_we,
  input  logic [IDX_W-1:0]                  wired_wdata,
`ifdef TLB_FLUSH_EN
  input  logic                              flush_req,
`endif
  output logic                              resp_valid,
  output tlb_entry_t                        resp_entry,
  output logic                              resp_hit,
  output logic [IDX_W-1:0]                  resp_index,
  output logic [IDX_W-1:0]                  random,
  output tlb_entry_t [TLB_ENTRIES-1:0]      tlb_table
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_RESP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                         state_reg, state_next;
  logic [IDX_W-1:0]               scan_idx_reg, scan_idx_next;
  logic [18:0]                    key_vpn2_reg;
  logic [7:0]                     key_asid_reg;
  logic [IDX_W-1:0]               random_reg;
  logic [IDX_W-1:0]               wired_reg;
  tlb_entry_t                     resp_entry_reg;
  logic                           resp_hit_reg;
  logic [IDX_W-1:0]               resp_index_reg;
  tlb_entry_t [TLB_ENTRIES-1:0]   table_reg;

  logic                           accept;
  logic                           wr_en;
  logic [IDX_W-1:0]               wr_idx;
  tlb_entry_t                     scan_entry;
  logic                           probe_match;
  logic                           scan_last;
  logic                           flush_start;

`ifdef TLB_FLUSH_EN
  assign flush_start = (state_reg == S_IDLE) && flush_req;
`else
  assign flush_start = 1'b0;
`endif

  // A pending flush steals the idle slot, so the pipeline sees not-ready.
  assign req_ready   = (state_reg == S_IDLE) && !flush_start;
  assign accept      = req_valid && req_ready;

  // TLBWR takes whatever Random shows in the accept cycle.
  assign wr_en       = accept && ((req_op == OP_TLBWI) || (req_op == OP_TLBWR));
  assign wr_idx      = (req_op == OP_TLBWR) ? random_reg : req_index;

  // Same match rule as the lookup units: VPN2 equal and (global or ASID equal).
  assign scan_entry  = table_reg[scan_idx_reg];
  assign probe_match = (state_reg == S_PROBE) &&
                       (scan_entry.vpn2 == key_vpn2_reg) &&
                       (scan_entry.g || (scan_entry.asid == key_asid_reg));
  assign scan_last   = (scan_idx_reg == LAST_IDX);

  assign resp_valid  = (state_reg == S_RESP);
  assign resp_entry  = resp_entry_reg;
  assign resp_hit    = resp_hit_reg;
  assign resp_index  = resp_index_reg;
  assign random      = random_reg;
  assign tlb_table   = table_reg;

  // Next-state logic; the scan counter is shared by PROBE and FLUSH.
  always_comb begin
    state_next    = state_reg;
    scan_idx_next = scan_idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (flush_start) begin
          state_next    = S_FLUSH;
          scan_idx_next = '0;
        end else if (accept) begin
          scan_idx_next = '0;
          state_next    = (req_op == OP_TLBP) ? S_PROBE : S_RESP;
        end
      end
      S_PROBE: begin
        if (probe_match || scan_last) state_next = S_RESP;
        else                          scan_idx_next = scan_idx_reg + 1'b1;
      end
      S_FLUSH: begin
        if (scan_last) state_next = S_RESP;
        else           scan_idx_next = scan_idx_reg + 1'b1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state, scan counter, probe key and response registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      scan_idx_reg   <= '0;
      key_vpn2_reg   <= '0;
      key_asid_reg   <= '0;
      resp_entry_reg <= '0;
      resp_hit_reg   <= 1'b0;
      resp_index_reg <= '0;
    end else begin
      state_reg    <= state_next;
      scan_idx_reg <= scan_idx_next;
      if (accept && (req_op == OP_TLBP)) begin
        key_vpn2_reg <= req_entry.vpn2;
        key_asid_reg <= req_entry.asid;
      end
      if (accept && (req_op == OP_TLBR))
        resp_entry_reg <= table_reg[req_index];
      if ((state_reg == S_PROBE) && (probe_match || scan_last)) begin
        resp_hit_reg   <= probe_match;
        resp_index_reg <= probe_match ? scan_idx_reg : '0;
      end
    end
  end

  // Random walks down from the top to Wired and wraps; a Wired write restarts it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      random_reg <= LAST_IDX;
      wired_reg  <= '0;
    end else if (wired_we) begin
      random_reg <= LAST_IDX;
      wired_reg  <= wired_wdata;
    end else if (random_reg <= wired_reg) begin
      random_reg <= LAST_IDX;
    end else begin
      random_reg <= random_reg - 1'b1;
    end
  end

  // Per-entry storage: written only by TLBWI/TLBWR or by the flush sweep.
  for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!resetn) begin
        table_reg[gi] <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        table_reg[gi] <= req_entry;
      end
`ifdef TLB_FLUSH_EN
      else if ((state_reg == S_FLUSH) && (scan_idx_reg == IDX_W'(gi))) begin
        table_reg[gi].v0 <= 1'b0;
        table_reg[gi].v1 <= 1'b0;
        table_reg[gi].g  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_tlb_write_unit.sv
// Directed testbench for tlb_write_unit (TLB_ENTRIES = 16).
module tb_tlb_write_unit;
  import tlb_write_unit_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [IW-1:0]        req_index;
  tlb_entry_t           req_entry;
  logic                 wired_we;
  logic [IW-1:0]        wired_wdata;
  logic                 flush_req;
  logic                 resp_valid;
  tlb_entry_t           resp_entry;
  logic                 resp_hit;
  logic [IW-1:0]        resp_index;
  logic [IW-1:0]        random;
  tlb_entry_t [N-1:0]   tlb_table;

  int n_checks = 0;
  int n_errors = 0;
  tlb_entry_t exp_tab [N];

  always #5 clk = ~clk;

  tlb_write_unit #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_entry(req_entry),
    .wired_we(wired_we), .wired_wdata(wired_wdata),
`ifdef TLB_FLUSH_EN
    .flush_req(flush_req),
`endif
    .resp_valid(resp_valid), .resp_entry(resp_entry), .resp_hit(resp_hit),
    .resp_index(resp_index), .random(random), .tlb_table(tlb_table)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s tab[%0d]", tag, i), 128'(tlb_table[i]), 128'(exp_tab[i]));
  endtask

  function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                    input logic g, input logic [19:0] pfn0,
                                    input logic [19:0] pfn1);
    tlb_entry_t e;
    e.vpn2 = vpn2; e.asid = asid; e.g = g;
    e.pfn0 = pfn0; e.pfn1 = pfn1;
    e.v0 = 1'b1; e.v1 = 1'b1; e.d0 = 1'b1; e.d1 = 1'b0;
    return e;
  endfunction

  // Issue one request and wait (bounded) for resp_valid; lat = cycles from accept.
  task automatic issue(input string tag, input logic [1:0] op, input logic [IW-1:0] idx,
                       input tlb_entry_t e, output int lat);
    check({tag, " ready_before"}, 128'(req_ready), 128'(1'b1));
    req_valid = 1'b1; req_op = op; req_index = idx; req_entry = e;
    tick();
    req_valid = 1'b0; req_entry = '0; req_index = '0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " ready_in_resp"}, 128'(req_ready), 128'(1'b0));
  endtask

  task automatic end_resp(input string tag);
    tick();
    check({tag, " pulse_ends"}, 128'(resp_valid), 128'(1'b0));
    check({tag, " ready_after"}, 128'(req_ready), 128'(1'b1));
  endtask

  initial begin
    tlb_entry_t e5, e5g, key, ew, e2, e9;
    int lat;
    int waited;
    bit saw_resp;

    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_index = '0;
    req_entry = '0; wired_we = 1'b0; wired_wdata = '0; flush_req = 1'b0;
    for (int i = 0; i < N; i++) exp_tab[i] = '0;

    // Reset state
    tick(); tick();
    check("rst random", 128'(random), 128'(4'd15));
    check("rst ready", 128'(req_ready), 128'(1'b1));
    check("rst resp_valid", 128'(resp_valid), 128'(1'b0));
    check("rst resp_hit", 128'(resp_hit), 128'(1'b0));
    check("rst resp_index", 128'(resp_index), 128'(4'd0));
    check("rst resp_entry", 128'(resp_entry), 128'(0));
    check_table("rst");
    resetn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("idle random %0d", k), 128'(random), 128'(15 - k));
    end

    // TLBWI entry 5
    e5 = mk(19'h12345, 8'h3A, 1'b0, 20'h100, 20'h101);
    issue("wi5", OP_TLBWI, 4'd5, e5, lat);
    exp_tab[5] = e5;
    check("wi5 latency", 128'(lat), 128'(1));
    check_table("wi5");
    end_resp("wi5");

    // TLBP hit at 5
    key = '0; key.vpn2 = 19'h12345; key.asid = 8'h3A;
    issue("p_hit", OP_TLBP, 4'd0, key, lat);
    check("p_hit latency", 128'(lat), 128'(7));
    check("p_hit hit", 128'(resp_hit), 128'(1'b1));
    check("p_hit index", 128'(resp_index), 128'(4'd5));
    end_resp("p_hit");

    // TLBP miss on ASID mismatch
    key.asid = 8'h3B;
    issue("p_miss", OP_TLBP, 4'd0, key, lat);
    check("p_miss latency", 128'(lat), 128'(17));
    check("p_miss hit", 128'(resp_hit), 128'(1'b0));
    check("p_miss index", 128'(resp_index), 128'(4'd0));
    end_resp("p_miss");

    // Make entry 5 global; the ASID-mismatched probe now hits
    e5g = e5; e5g.g = 1'b1;
    issue("wi5g", OP_TLBWI, 4'd5, e5g, lat);
    exp_tab[5] = e5g;
    check("wi5g latency", 128'(lat), 128'(1));
    end_resp("wi5g");
    issue("p_glob", OP_TLBP, 4'd0, key, lat);
    check("p_glob latency", 128'(lat), 128'(7));
    check("p_glob hit", 128'(resp_hit), 128'(1'b1));
    check("p_glob index", 128'(resp_index), 128'(4'd5));
    end_resp("p_glob");

    // TLBR entry 5, then empty entry 0
    issue("r5", OP_TLBR, 4'd5, mk(19'h1, 8'h2, 1'b0, 20'h3, 20'h4), lat);
    check("r5 latency", 128'(lat), 128'(1));
    check("r5 entry", 128'(resp_entry), 128'(e5g));
    end_resp("r5");
    check("r5 entry holds", 128'(resp_entry), 128'(e5g));
    issue("r0", OP_TLBR, 4'd0, '0, lat);
    check("r0 entry", 128'(resp_entry), 128'(0));
    end_resp("r0");

    // Wired = 12, Random restarts at 15 and cycles 15..12
    wired_we = 1'b1; wired_wdata = 4'd12;
    tick();
    wired_we = 1'b0;
    check("wired random0", 128'(random), 128'(4'd15));
    tick(); check("wired random1", 128'(random), 128'(4'd14));
    tick(); check("wired random2", 128'(random), 128'(4'd13));
    tick(); check("wired random3", 128'(random), 128'(4'd12));
    tick(); check("wired random4", 128'(random), 128'(4'd15));
    tick(); check("wired random5", 128'(random), 128'(4'd14));
    waited = 0;
    while (random != 4'd13 && waited < 10) begin
      tick();
      waited++;
    end
    check("wr random_at_issue", 128'(random), 128'(4'd13));

    // TLBWR writes only entry 13, ignoring req_index
    ew = mk(19'h07777, 8'h01, 1'b0, 20'h777, 20'h778);
    issue("wr", OP_TLBWR, 4'd3, ew, lat);
    exp_tab[13] = ew;
    check("wr latency", 128'(lat), 128'(1));
    check_table("wr");
    end_resp("wr");

    // Duplicate matches at 2 and 9: lowest index wins
    e2 = mk(19'h0ABCD, 8'h11, 1'b0, 20'h200, 20'h201);
    e9 = mk(19'h0ABCD, 8'h11, 1'b0, 20'h900, 20'h901);
    issue("wi2", OP_TLBWI, 4'd2, e2, lat); end_resp("wi2");
    issue("wi9", OP_TLBWI, 4'd9, e9, lat); end_resp("wi9");
    exp_tab[2] = e2; exp_tab[9] = e9;
    key = '0; key.vpn2 = 19'h0ABCD; key.asid = 8'h11;
    issue("p_dup", OP_TLBP, 4'd0, key, lat);
    check("p_dup latency", 128'(lat), 128'(4));
    check("p_dup hit", 128'(resp_hit), 128'(1'b1));
    check("p_dup index", 128'(resp_index), 128'(4'd2));
    end_resp("p_dup");
    check_table("dup");

    // Reset in the middle of a probe aborts it
    req_valid = 1'b1; req_op = OP_TLBP; req_entry = '0;
    req_entry.vpn2 = 19'h55555;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    check("abort busy", 128'(req_ready), 128'(1'b0));
    resetn = 1'b0;
    tick();
    for (int i = 0; i < N; i++) exp_tab[i] = '0;
    check_table("abort");
    check("abort resp_valid", 128'(resp_valid), 128'(1'b0));
    check("abort resp_hit", 128'(resp_hit), 128'(1'b0));
    check("abort resp_index", 128'(resp_index), 128'(4'd0));
    check("abort resp_entry", 128'(resp_entry), 128'(0));
    check("abort random", 128'(random), 128'(4'd15));
    resetn = 1'b1;
    tick();
    check("abort ready", 128'(req_ready), 128'(1'b1));
    check("abort random_wired0", 128'(random), 128'(4'd14));
    saw_resp = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid) saw_resp = 1'b1;
      tick();
    end
    check("abort no_resp", 128'(saw_resp), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb_write_unit.md
Name: tlb_write_unit

Overview:
- Owns the architectural TLB table registers.
- Executes the CP0 TLB maintenance instructions TLBR, TLBWI, TLBWR and TLBP for the pipeline.
- Drives the shared `tlb_table` consumed by the lookup units, and maintains the Random and Wired registers.
- Sits beside CP0. Pipeline stalls on `req_ready`/`resp_valid`.

Parameters:
- TLB_ENTRIES, 16, number of entries (power of 2, ≥2).
- IDX_W, $clog2(TLB_ENTRIES), index width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  instruction request
- req_ready  out  1  unit idle and accepting
- req_op  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
- req_index  in  IDX_W  CP0 Index (TLBR/TLBWI)
- req_entry  in  tlb_entry_t  entry built from EntryHi/EntryLo0/EntryLo1/PageMask (writes; vpn2/asid also used as the TLBP key)
- wired_we  in  1  Wired register write
- wired_wdata  in  IDX_W  new Wired value
- resp_valid  out  1  one-cycle completion pulse
- resp_entry  out  tlb_entry_t  TLBR read data
- resp_hit  out  1  TLBP hit
- resp_index  out  IDX_W  TLBP matching index
- random  out  IDX_W  CP0 Random
- tlb_table  out  tlb_table_t  full table to lookup units

Behaviour:
- Reset (`resetn`=0 at a clk edge):
  - All entry fields cleared (vpn2=0, asid=0, G=0, pfn0/pfn1=0, v0/v1=0, d0/d1=0).
  - FSM returns to IDLE.
  - `resp_valid`=0, `resp_hit`=0, `resp_index`=0, `resp_entry`=0.
  - `random`=TLB_ENTRIES-1, Wired=0.
  - Reset mid-operation aborts with no response.
- FSM states: IDLE, PROBE, RESP.
  - `req_ready`=1 only in IDLE.
  - Handshake: a request is accepted on the edge where `req_valid` && `req_ready`.
  - The request fields are sampled only at acceptance.
- TLBWI:
  - `tlb_table[req_index]` <= `req_entry` at the accept edge.
  - Next cycle goes to RESP. `resp_valid`=1 for exactly one cycle, then IDLE.
  - The new entry is visible on `tlb_table` the cycle after accept.
- TLBWR: same as TLBWI, using the value of `random` in the accept cycle as the index.
- TLBR:
  - `resp_entry` <= `tlb_table[req_index]` captured at the accept edge.
  - RESP next cycle. `resp_entry` holds until the next TLBR.
- TLBP:
  - Key is `req_entry.vpn2` and `req_entry.asid`, latched at accept.
  - PROBE scans one entry per cycle, starting at 0.
  - Match rule: vpn2 equal AND (entry.G OR asid equal). This is the same rule as the lookup units.
  - On the first (lowest-index) match: `resp_hit`=1, `resp_index`=i, go to RESP.
  - After entry TLB_ENTRIES-1 with no match: `resp_hit`=0, `resp_index`=0, go to RESP.
  - Latency, accept to `resp_valid`: i+2 cycles on a hit at i; TLB_ENTRIES+1 cycles on a miss.
  - `resp_hit`/`resp_index` hold until the next TLBP.
- Random:
  - Updated every cycle regardless of FSM state: if `random` ≤ Wired, next = TLB_ENTRIES-1; else `random` - 1.
  - It therefore cycles through [Wired, TLB_ENTRIES-1].
  - If Wired = TLB_ENTRIES-1, `random` stays at TLB_ENTRIES-1.
  - `wired_we`: Wired <= `wired_wdata` and `random` <= TLB_ENTRIES-1 on that edge. This takes priority over the decrement.
  - `wired_we` is allowed in any FSM state.
  - A TLBWR accepted in the same cycle as `wired_we` uses the pre-update `random`.
- Table writes occur only via TLBWI/TLBWR (and flush when enabled). No write happens in any other cycle.

Optional Feature:
- Macro `TLB_FLUSH_EN`.
- When defined:
  - Adds input `flush_req` (1 bit) and FSM state FLUSH.
  - `flush_req` is accepted in IDLE with priority over `req_valid`; `req_ready`=0 in that cycle.
  - FLUSH clears v0, v1 and G of entries 0..TLB_ENTRIES-1, one entry per cycle. Other fields are unchanged.
  - Then RESP: one `resp_valid` pulse. Total TLB_ENTRIES+1 cycles.
- When undefined: the port and state are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then idle 3 cycles -> `random` sequence 15,14,13,12 (TLB_ENTRIES=16); `req_ready`=1; all `tlb_table` v0/v1=0.
- TLBWI with `req_index`=5, vpn2=0x12345, asid=0x3A, G=0, pfn0=0x100, pfn1=0x101 -> `tlb_table[5]` matches the next cycle; `resp_valid` one cycle later.
- After the above, TLBP with vpn2=0x12345, asid=0x3A -> `resp_hit`=1, `resp_index`=5, `resp_valid` 7 cycles after accept. Same TLBP with asid=0x3B -> `resp_hit`=0 after 17 cycles. Set G=1 on entry 5 -> hit.
- TLBR with `req_index`=5 -> `resp_entry` equals the written entry; `resp_valid` 1 cycle after accept; `req_ready`=0 in between.
- `wired_we` with 12 -> `random`=15 next cycle, then 14,13,12,15,14… Issue TLBWR when `random`=13 -> only entry 13 is written.
- Duplicate matches at entries 2 and 9, TLBP -> `resp_index`=2. Assert `resetn` during PROBE -> no `resp_valid`, table cleared, `req_ready`=1 after release.
